// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a line-burst memory bus.
// Optional WAIT timeout is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int BUS_SIZE  = 16,
  parameter int ADDR_SIZE = 15,
  parameter int BEATS     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           c0_cmd,
  input  logic [1:0]           c1_cmd,
  input  logic [ADDR_SIZE-1:0] c0_addr,
  input  logic [ADDR_SIZE-1:0] c1_addr,
  input  logic [BUS_SIZE-1:0]  c0_wdata,
  input  logic [BUS_SIZE-1:0]  c1_wdata,
  output logic                 c0_gnt,
  output logic                 c1_gnt,
  output logic                 c0_resp,
  output logic                 c1_resp,
  output logic [BUS_SIZE-1:0]  c0_rdata,
  output logic [BUS_SIZE-1:0]  c1_rdata,
  output logic                 c0_err,
  output logic                 c1_err,
  output logic [1:0]           mem_cmd,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [BUS_SIZE-1:0]  mem_wdata,
  input  logic [1:0]           mem_rsp,
  input  logic [BUS_SIZE-1:0]  mem_rdata
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, CMD, WAIT, BURST, DONE} state_t;

  state_t               state, state_nx;
  logic                 owner, owner_nx;
  logic                 prio, prio_nx;
  logic [1:0]           cmd_q, cmd_nx;
  logic [ADDR_SIZE-1:0] addr_q, addr_nx;
  logic [BW-1:0]        beat, beat_nx;
  logic                 req0, req1, active, beat_ok;

  // Only READ (2) and WRITE (3) request the bus; 1 behaves as NOP.
  assign req0    = c0_cmd[1];
  assign req1    = c1_cmd[1];
  assign active  = (state == CMD) || (state == WAIT) || (state == BURST);
  assign beat_ok = ((state == WAIT) || (state == BURST)) && (mem_rsp == 2'd1);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wait_cnt, wait_nx;
  logic          err_pulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt <= '0;
    else          wait_cnt <= wait_nx;
  end

  assign c0_err = err_pulse & ~owner;
  assign c1_err = err_pulse &  owner;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign c0_err = 1'b0;
  assign c1_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    prio_nx  = prio;
    cmd_nx   = cmd_q;
    addr_nx  = addr_q;
    beat_nx  = beat;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_nx   = '0;
    err_pulse = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nx = (req0 && req1) ? prio : req1;
          cmd_nx   = owner_nx ? c1_cmd  : c0_cmd;
          addr_nx  = owner_nx ? c1_addr : c0_addr;
          state_nx = CMD;
        end
      end
      CMD: state_nx = WAIT;
      WAIT, BURST: begin
        if (beat_ok) begin
          // Last beat: rr pointer moves past the requester just served.
          if (beat == BW'(BEATS - 1)) begin
            beat_nx  = '0;
            prio_nx  = ~owner;
            state_nx = DONE;
          end else begin
            beat_nx  = beat + 1'b1;
            state_nx = BURST;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (state == WAIT) begin
          if (wait_cnt == TW'(TIMEOUT - 1)) begin
            err_pulse = 1'b1;
            prio_nx   = ~owner;
            state_nx  = DONE;
          end else begin
            wait_nx = wait_cnt + 1'b1;
          end
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      cmd_q  <= '0;
      addr_q <= '0;
      beat   <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      prio   <= prio_nx;
      cmd_q  <= cmd_nx;
      addr_q <= addr_nx;
      beat   <= beat_nx;
    end
  end

  assign c0_gnt    = active & ~owner;
  assign c1_gnt    = active &  owner;
  assign c0_resp   = beat_ok & ~owner;
  assign c1_resp   = beat_ok &  owner;
  assign c0_rdata  = c0_resp ? mem_rdata : '0;
  assign c1_rdata  = c1_resp ? mem_rdata : '0;
  assign mem_cmd   = (state == CMD) ? cmd_q : 2'b00;
  assign mem_addr  = addr_q;
  assign mem_wdata = c0_gnt ? c0_wdata : (c1_gnt ? c1_wdata : '0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transfer-level model sets per-cycle
// expectations, one negedge process compares them, plus literal spot checks.
module tb_mem_bus_arbiter;
  localparam int BUS = 16;
  localparam int AW  = 15;
  localparam int NB  = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     c0_cmd, c1_cmd;
  logic [AW-1:0]  c0_addr, c1_addr;
  logic [BUS-1:0] c0_wdata, c1_wdata;
  logic           c0_gnt, c1_gnt, c0_resp, c1_resp, c0_err, c1_err;
  logic [BUS-1:0] c0_rdata, c1_rdata;
  logic [1:0]     mem_cmd;
  logic [AW-1:0]  mem_addr;
  logic [BUS-1:0] mem_wdata;
  logic [1:0]     mem_rsp;
  logic [BUS-1:0] mem_rdata;

  mem_bus_arbiter #(.BUS_SIZE(BUS), .ADDR_SIZE(AW), .BEATS(NB), .TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_cmd(c0_cmd), .c1_cmd(c1_cmd), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_resp(c0_resp), .c1_resp(c1_resp),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata), .c0_err(c0_err), .c1_err(c1_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp(mem_rsp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic           e_gnt0, e_gnt1, e_resp0, e_resp1, e_err0, e_err1, e_addr_vld;
  logic [BUS-1:0] e_rdata0, e_rdata1, e_mem_wdata;
  logic [1:0]     e_mem_cmd;
  logic [AW-1:0]  e_mem_addr;
  bit             chk_on = 1'b0;

  int             prio;        // model: requester that wins a tie
  int             served[$];   // model: grant order
  int             resp_cnt[2];
  int             err_cnt[2];
  logic [1:0]     last_cmd;
  logic [AW-1:0]  last_addr;
  logic [BUS-1:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int own, input bit act, input bit rsp, input bit err,
                         input logic [1:0] mc);
    e_gnt0      = act && (own == 0);
    e_gnt1      = act && (own == 1);
    e_resp0     = rsp && (own == 0);
    e_resp1     = rsp && (own == 1);
    e_rdata0    = e_resp0 ? mem_rdata : '0;
    e_rdata1    = e_resp1 ? mem_rdata : '0;
    e_err0      = err && (own == 0);
    e_err1      = err && (own == 1);
    e_mem_cmd   = mc;
    e_mem_wdata = act ? ((own == 1) ? c1_wdata : c0_wdata) : '0;
    e_addr_vld  = act;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("c0_gnt",    32'(c0_gnt),    32'(e_gnt0));
      chk("c1_gnt",    32'(c1_gnt),    32'(e_gnt1));
      chk("c0_resp",   32'(c0_resp),   32'(e_resp0));
      chk("c1_resp",   32'(c1_resp),   32'(e_resp1));
      chk("c0_rdata",  32'(c0_rdata),  32'(e_rdata0));
      chk("c1_rdata",  32'(c1_rdata),  32'(e_rdata1));
      chk("c0_err",    32'(c0_err),    32'(e_err0));
      chk("c1_err",    32'(c1_err),    32'(e_err1));
      chk("mem_cmd",   32'(mem_cmd),   32'(e_mem_cmd));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      if (e_addr_vld) chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    end
  end

  always @(negedge clk) begin
    if (c0_resp) resp_cnt[0]++;
    if (c1_resp) resp_cnt[1]++;
    if (c0_err)  err_cnt[0]++;
    if (c1_err)  err_cnt[1]++;
    if (mem_cmd != 2'd0) begin
      last_cmd   = mem_cmd;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    c0_cmd = 2'd0; c1_cmd = 2'd0; mem_rsp = 2'd0; mem_rdata = '0;
    prio = 0;
    served.delete();
    set_exp(0, 0, 0, 0, 2'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One transfer starting at the IDLE cycle in which the requests are presented.
  task automatic run_xfer(input int lat, input int stall_before, input int stall_len,
                          input int abort_at, input int tmo, input logic [BUS-1:0] base);
    int own, b, st;
    bit r0, r1;
    logic [1:0]     cmd;
    logic [AW-1:0]  addr;
    logic [BUS-1:0] wd;
    r0 = (c0_cmd == 2'd2) || (c0_cmd == 2'd3);
    r1 = (c1_cmd == 2'd2) || (c1_cmd == 2'd3);
    own  = (r0 && r1) ? prio : (r1 ? 1 : 0);
    cmd  = (own == 1) ? c1_cmd : c0_cmd;
    addr = (own == 1) ? c1_addr : c0_addr;
    wd   = (own == 1) ? c1_wdata : c0_wdata;
    served.push_back(own);
    mem_rsp = 2'd1; mem_rdata = 16'hDEAD;
    set_exp(own, 0, 0, 0, 2'd0);
    step();
    // Requester changes its command/address after the sample; must be ignored.
    if (own == 1) begin c1_cmd = (cmd == 2'd2) ? 2'd3 : 2'd2; c1_addr = addr ^ {AW{1'b1}}; end
    else          begin c0_cmd = (cmd == 2'd2) ? 2'd3 : 2'd2; c0_addr = addr ^ {AW{1'b1}}; end
    e_mem_addr = addr;
    set_exp(own, 1, 0, 0, cmd);
    step();
    for (int k = 0; k < lat; k++) begin
      mem_rsp   = (k % 3 == 1) ? 2'd2 : ((k % 3 == 2) ? 2'd3 : 2'd0);
      mem_rdata = 16'hBEEF;
      set_exp(own, 1, 0, (tmo > 0) && (k == tmo - 1), 2'd0);
      step();
    end
    if (tmo == 0) begin
      b = 0; st = 0;
      while (b < NB) begin
        if (b == abort_at) begin
          mem_rsp = 2'd1; mem_rdata = 16'hC0DE; reset_n = 1'b0;
          #1;
          chk("rst_c0_gnt",    32'(c0_gnt),    32'd0);
          chk("rst_c1_gnt",    32'(c1_gnt),    32'd0);
          chk("rst_c0_resp",   32'(c0_resp),   32'd0);
          chk("rst_c1_resp",   32'(c1_resp),   32'd0);
          chk("rst_c0_rdata",  32'(c0_rdata),  32'd0);
          chk("rst_mem_cmd",   32'(mem_cmd),   32'd0);
          chk("rst_mem_addr",  32'(mem_addr),  32'd0);
          chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
          prio = 0;
          set_exp(0, 0, 0, 0, 2'd0);
          step();
          step();
          reset_n = 1'b1; mem_rsp = 2'd0;
          return;
        end
        if (b == stall_before && st < stall_len) begin
          mem_rsp = 2'd0; mem_rdata = 16'h5A5A; st++;
          set_exp(own, 1, 0, 0, 2'd0);
        end else begin
          mem_rsp = 2'd1; mem_rdata = base + BUS'(b + 1);
          if (own == 1) c1_wdata = BUS'($urandom); else c0_wdata = BUS'($urandom);
          set_exp(own, 1, 1, 0, 2'd0);
          b++;
        end
        step();
      end
    end
    mem_rsp = 2'd1; mem_rdata = 16'hDEAD;
    if (own == 1) begin c1_cmd = cmd; c1_addr = addr; c1_wdata = wd; end
    else          begin c0_cmd = cmd; c0_addr = addr; c0_wdata = wd; end
    set_exp(own, 0, 0, 0, 2'd0);
    prio = (own == 1) ? 0 : 1;
    step();
  endtask

  initial begin
    c0_cmd = 2'd0; c1_cmd = 2'd0; c0_addr = '0; c1_addr = '0;
    c0_wdata = '0; c1_wdata = '0; mem_rsp = 2'd0; mem_rdata = '0;
    prio = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("init_c0_gnt",   32'(c0_gnt),   32'd0);
    chk("init_c1_gnt",   32'(c1_gnt),   32'd0);
    chk("init_mem_cmd",  32'(mem_cmd),  32'd0);
    chk("init_mem_addr", 32'(mem_addr), 32'd0);
    set_exp(0, 0, 0, 0, 2'd0);
    chk_on = 1'b1;
    do_reset();

    // Single read from c0
    resp_cnt[0] = 0;
    c0_cmd = 2'd2; c0_addr = 15'h1A3; c0_wdata = 16'h0F0F;
    run_xfer(3, -1, 0, -1, 0, 16'h0000);
    c0_cmd = 2'd0;
    chk("t1_beats", 32'(resp_cnt[0]), 32'd8);
    chk("t1_cmd",   32'(last_cmd),    32'd2);
    chk("t1_addr",  32'(last_addr),   32'h1A3);

    // Simultaneous: c0 READ, c1 WRITE; c0 wins after reset
    do_reset();
    c0_cmd = 2'd2; c0_addr = 15'h055; c0_wdata = 16'h1111;
    c1_cmd = 2'd3; c1_addr = 15'h2F0; c1_wdata = 16'h2BEE;
    run_xfer(2, -1, 0, -1, 0, 16'h1000);
    c0_cmd = 2'd0;
    run_xfer(1, -1, 0, -1, 0, 16'h2000);
    c1_cmd = 2'd0;
    chk("t2_first",  32'(served[0]),  32'd0);
    chk("t2_second", 32'(served[1]),  32'd1);
    chk("t2_cmd",    32'(last_cmd),   32'd3);
    chk("t2_wdata",  32'(last_wdata), 32'h2BEE);

    // Round robin with both requests held
    do_reset();
    c0_cmd = 2'd2; c0_addr = 15'h100; c0_wdata = 16'hA0A0;
    c1_cmd = 2'd3; c1_addr = 15'h200; c1_wdata = 16'hB0B0;
    for (int t = 0; t < 4; t++) run_xfer(t, -1, 0, -1, 0, BUS'(t * 16'h0100));
    c0_cmd = 2'd0; c1_cmd = 2'd0;
    chk("t3_order0", 32'(served[0]), 32'd0);
    chk("t3_order1", 32'(served[1]), 32'd1);
    chk("t3_order2", 32'(served[2]), 32'd0);
    chk("t3_order3", 32'(served[3]), 32'd1);

    // Burst stall of 2 cycles after beat 3
    do_reset();
    resp_cnt[0] = 0;
    c0_cmd = 2'd2; c0_addr = 15'h321;
    run_xfer(1, 4, 2, -1, 0, 16'h0100);
    c0_cmd = 2'd0;
    step();
    chk("t4_beats", 32'(resp_cnt[0]), 32'd8);

    // Reset mid-burst, then cmd=1 is a NOP and a lone c1 READ is granted
    do_reset();
    c0_cmd = 2'd2; c0_addr = 15'h0AB;
    run_xfer(2, -1, 0, 5, 0, 16'h0400);
    served.delete();
    c0_cmd = 2'd1; c1_cmd = 2'd0;
    set_exp(0, 0, 0, 0, 2'd0);
    for (int k = 0; k < 3; k++) step();
    c1_cmd = 2'd2; c1_addr = 15'h333;
    run_xfer(2, -1, 0, -1, 0, 16'h0500);
    c0_cmd = 2'd0; c1_cmd = 2'd0;
    chk("t5_owner", 32'(served[0]), 32'd1);
    chk("t5_addr",  32'(last_addr), 32'h333);

    do_reset();
    err_cnt[0] = 0; err_cnt[1] = 0;
    c1_cmd = 2'd2; c1_addr = 15'h777;
`ifdef MEM_ARB_TIMEOUT_EN
    run_xfer(10, -1, 0, -1, 10, 16'h0000);
    c1_cmd = 2'd0;
    set_exp(0, 0, 0, 0, 2'd0);
    step();
    chk("t6_err_pulses", 32'(err_cnt[1]), 32'd1);
    chk("t6_c0_err",     32'(err_cnt[0]), 32'd0);
`else
    run_xfer(20, -1, 0, -1, 0, 16'h0600);
    c1_cmd = 2'd0;
    set_exp(0, 0, 0, 0, 2'd0);
    step();
    chk("t6_no_err", 32'(err_cnt[0] + err_cnt[1]), 32'd0);
`endif

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
